// File: rtl/muldiv_sequencer_if.sv
// Operand/result handshake bundle between the execute stage and the RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(
   parameter int XLEN = 32,
   parameter int TAGW = 5
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      in_op;
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_b;
   logic [TAGW-1:0] in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_data;
   logic [TAGW-1:0] out_tag;
   logic            busy;

   modport master (
      output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, busy
   );

   modport slave (
      input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, busy
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit: shift-add multiply / restoring divide, one bit per cycle,
// with sign fix-up and a tagged valid/ready result port.
module muldiv_sequencer #(
   parameter int XLEN = 32,
   parameter int TAGW = 5
) (
   input  logic              clk,
   input  logic              rst,
   muldiv_sequencer_if.slave bus
);
   localparam int CNTW = $clog2(XLEN);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [TAGW-1:0]   tag_q, tag_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   mag_q, mag_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic              rneg_q, rneg_d;
   logic [XLEN-1:0]   out_data_q, out_data_d;

   logic              is_div, sgn_a, sgn_b, a_neg, b_neg;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic [XLEN:0]     msum, trial;
   logic [2*XLEN-1:0] prod;

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   always_comb begin
      is_div   = op_q[2];
      sgn_a    = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
      sgn_b    = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
      a_neg    = sgn_a && a_q[XLEN-1];
      b_neg    = sgn_b && b_q[XLEN-1];
      a_abs    = cond_neg(a_q, a_neg);
      b_abs    = cond_neg(b_q, b_neg);
      div_zero = is_div && (b_q == '0);
      div_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                 (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
      // Remainder is at most divisor-1, so the shifted partial remainder needs XLEN+1 bits.
      msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mag_q};
      trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mag_q};
      prod     = neg_q ? -acc_q : acc_q;
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      tag_d      = tag_q;
      a_d        = a_q;
      b_d        = b_q;
      mag_d      = mag_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      neg_d      = neg_q;
      rneg_d     = rneg_q;
      out_data_d = out_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               op_d    = bus.in_op;
               tag_d   = bus.in_tag;
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            mag_d  = b_abs;
            acc_d  = {{XLEN{1'b0}}, a_abs};
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
            cnt_d  = '0;
            if (div_zero) begin
               out_data_d = op_q[1] ? a_q : '1;
               state_d    = S_DONE;
            end else if (div_ovf) begin
               out_data_d = op_q[1] ? '0 : a_q;
               state_d    = S_DONE;
            end else begin
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            if (is_div) begin
               acc_d = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
               acc_d = acc_q[0] ? {msum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
            end
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(XLEN-1)) begin
               state_d = S_FIXUP;
            end
         end
         S_FIXUP: begin
            unique case (op_q)
               OP_MUL:                     out_data_d = prod[XLEN-1:0];
               OP_MULH, OP_MULHSU, OP_MULHU: out_data_d = prod[2*XLEN-1:XLEN];
               OP_DIV, OP_DIVU:            out_data_d = cond_neg(acc_q[XLEN-1:0], neg_q);
               default:                    out_data_d = cond_neg(acc_q[2*XLEN-1:XLEN], rneg_q);
            endcase
            state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (bus.flush) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tag_q      <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         tag_q      <= tag_d;
         out_data_q <= out_data_d;
      end
   end

   always_ff @(posedge clk) begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      mag_q  <= mag_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
   end

   assign bus.in_ready  = (state_q == S_IDLE) && !rst;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.out_data  = out_data_q;
   assign bus.out_tag   = tag_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized bench for muldiv_sequencer against a plain-arithmetic RV32M model.
module tb_muldiv_sequencer;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   muldiv_sequencer_if #(.XLEN(32), .TAGW(5)) bus ();

   muldiv_sequencer #(.XLEN(32), .TAGW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint     sa, sb, ub;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      r  = '0;
      case (op)
         3'd0: begin r = {32'b0, a} * {32'b0, b}; return r[31:0]; end
         3'd1: begin r = sa * sb; return r[63:32]; end
         3'd2: begin r = sa * ub; return r[63:32]; end
         3'd3: begin r = {32'b0, a} * {32'b0, b}; return r[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            r = sa / sb; return r[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            r = sa % sb; return r[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op >= 3'd4 && b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Issues one op; hold>0 keeps out_ready low that many cycles in DONE and leaves it low.
   task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input int hold);
      logic [31:0] exp;
      int          n, explat, busy_cnt;
      exp           = ref_op(op, a, b);
      explat        = ref_lat(op, a, b);
      bus.in_op     = op;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_tag    = tag;
      bus.in_valid  = 1'b1;
      bus.out_ready = (hold == 0);
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.in_a      = $urandom;
      bus.in_b      = $urandom;
      bus.in_op     = 3'($urandom_range(0, 7));
      bus.in_tag    = 5'($urandom_range(0, 31));
      n = 0;
      busy_cnt = bus.busy ? 1 : 0;
      while (!bus.out_valid && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (bus.busy) busy_cnt++;
      end
      check({nm, "_latency"}, 32'(n), 32'(explat));
      check({nm, "_data"}, bus.out_data, exp);
      check({nm, "_tag"}, {27'b0, bus.out_tag}, {27'b0, tag});
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check1({nm, "_hold_valid"}, bus.out_valid, 1'b1);
            check({nm, "_hold_data"}, bus.out_data, exp);
            check({nm, "_hold_tag"}, {27'b0, bus.out_tag}, {27'b0, tag});
            check1({nm, "_hold_busy"}, bus.busy, 1'b1);
            check1({nm, "_hold_inready"}, bus.in_ready, 1'b0);
         end
      end else begin
         @(posedge clk); #1;
         check(
            {nm, "_busy_cycles"}, 32'(busy_cnt), 32'(explat + 1));
         check1({nm, "_post_valid"}, bus.out_valid, 1'b0);
         check1({nm, "_post_busy"}, bus.busy, 1'b0);
         check1({nm, "_post_inready"}, bus.in_ready, 1'b1);
      end
   endtask

   initial begin
      logic        seen;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          sel;
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 3'd0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check1("rst_inready", bus.in_ready, 1'b0);
      check1("rst_valid", bus.out_valid, 1'b0);
      check1("rst_busy", bus.busy, 1'b0);
      check("rst_data", bus.out_data, 32'h0);
      check("rst_tag", {27'b0, bus.out_tag}, 32'h0);
      rst = 1'b0;
      #1;
      check1("rel_inready", bus.in_ready, 1'b1);

      do_op("mul",     3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  0);
      check("mul_value", bus.out_data, 32'hFFFF_FFEB);
      do_op("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  0);
      check("mulh_value", bus.out_data, 32'h4000_0000);
      do_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  0);
      check("mulhu_value", bus.out_data, 32'hFFFF_FFFE);
      do_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  0);
      check("mulhsu_value", bus.out_data, 32'hFFFF_FFFF);
      do_op("div",     3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  0);
      check("div_value", bus.out_data, 32'hFFFF_FFFD);
      do_op("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  0);
      check("rem_value", bus.out_data, 32'hFFFF_FFFF);
      do_op("divu",    3'd5, 32'hFFFF_FFFF, 32'd16,        5'd7,  0);
      check("divu_value", bus.out_data, 32'h0FFF_FFFF);
      do_op("remu",    3'd7, 32'hFFFF_FFFF, 32'd16,        5'd8,  0);
      check("remu_value", bus.out_data, 32'h0000_000F);
      do_op("div0",    3'd4, 32'd5,         32'd0,         5'd9,  0);
      check("div0_value", bus.out_data, 32'hFFFF_FFFF);
      do_op("rem0",    3'd6, 32'd5,         32'd0,         5'd10, 0);
      check("rem0_value", bus.out_data, 32'd5);
      do_op("divovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
      check("divovf_value", bus.out_data, 32'h8000_0000);
      do_op("removf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
      check("removf_value", bus.out_data, 32'h0);

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         sel = $urandom_range(0, 5);
         case (sel)
            1: rb = 32'h0;
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: begin ra = 32'($urandom_range(0, 100)); rb = 32'($urandom_range(0, 9)) - 32'd5; end
            4: ra = 32'h8000_0000;
            default: ;
         endcase
         do_op("rand", rop, ra, rb, 5'($urandom_range(0, 31)), 0);
      end

      do_op("bp", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, 10);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_op     = 3'd5;
      bus.in_a      = 32'd1000;
      bus.in_b      = 32'd7;
      bus.in_tag    = 5'd22;
      @(posedge clk); #1;
      check1("bp_release_valid", bus.out_valid, 1'b0);
      check1("bp_no_accept_busy", bus.busy, 1'b0);
      check1("bp_inready_next", bus.in_ready, 1'b1);
      do_op("bp_next", 3'd5, 32'd1000, 32'd7, 5'd22, 0);

      bus.in_op     = 3'd0;
      bus.in_a      = $urandom;
      bus.in_b      = $urandom;
      bus.in_tag    = 5'd13;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (11) begin @(posedge clk); #1; end
      check1("flush_pre_busy", bus.busy, 1'b1);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check1("flush_busy", bus.busy, 1'b0);
      check1("flush_inready", bus.in_ready, 1'b1);
      seen = 1'b0;
      repeat (50) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1'b1;
      end
      check1("flush_no_valid", seen, 1'b0);
      do_op("after_flush", 3'd6, 32'hFFFF_FF9C, 32'd7, 5'd14, 0);

      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check1("flush_idle_no_accept", bus.busy, 1'b0);

      bus.in_op    = 3'd4;
      bus.in_a     = 32'd999;
      bus.in_b     = 32'd3;
      bus.in_tag   = 5'd9;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (15) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check1("rst_mid_inready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      check1("rst_mid_valid", bus.out_valid, 1'b0);
      check1("rst_mid_busy", bus.busy, 1'b0);
      check("rst_mid_data", bus.out_data, 32'h0);
      check("rst_mid_tag", {27'b0, bus.out_tag}, 32'h0);
      check1("rst_mid_inready_held", bus.in_ready, 1'b0);
      rst = 1'b0;
      #1;
      check1("rst_mid_release", bus.in_ready, 1'b1);
      do_op("after_rst", 3'd7, 32'd12345, 32'd100, 5'd30, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
